// File: rtl/sd_cmd_engine_if.sv
// SD command-path bundle: host command register side, CMD line pins and
// response register write port.
interface sd_cmd_engine_if;
  logic        cmd_start;
  logic [15:0] cmd_in;
  logic [31:0] arg_in;
  logic        sd_bit_en;
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        sd_cmd_in;
  logic [31:0] resp0_d;
  logic [31:0] resp1_d;
  logic [31:0] resp2_d;
  logic [31:0] resp3_d;
  logic        resp0_we;
  logic        resp1_we;
  logic        resp2_we;
  logic        resp3_we;
  logic        cmd_inhibit;
  logic        cmd_complete;
  logic        timeout_err;
  logic        crc_err;
  logic        end_bit_err;
  logic        index_err;

  modport slave (
    input  cmd_start, cmd_in, arg_in, sd_bit_en, sd_cmd_in,
    output sd_cmd_out, sd_cmd_oe,
    output resp0_d, resp1_d, resp2_d, resp3_d,
    output resp0_we, resp1_we, resp2_we, resp3_we,
    output cmd_inhibit, cmd_complete, timeout_err, crc_err, end_bit_err, index_err
  );

  modport master (
    output cmd_start, cmd_in, arg_in, sd_bit_en, sd_cmd_in,
    input  sd_cmd_out, sd_cmd_oe,
    input  resp0_d, resp1_d, resp2_d, resp3_d,
    input  resp0_we, resp1_we, resp2_we, resp3_we,
    input  cmd_inhibit, cmd_complete, timeout_err, crc_err, end_bit_err, index_err
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD command engine: serialises a 48-bit command frame on CMD, then collects
// and checks an optional 48- or 136-bit response, one bit per SD clock strobe.
module sd_cmd_engine #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  sd_cmd_engine_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    RECV = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST   = 8'(RESP_TIMEOUT - 1);
  localparam logic [7:0] FRAME_BITS = 8'd48;
  localparam logic [7:0] LAST48     = 8'd46;
  localparam logic [7:0] LAST136    = 8'd134;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    logic [6:0]  crc;
    body = {2'b01, idx, arg};
    crc  = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      crc = crc7_step(crc, body[i]);
    end
    return {body, crc, 1'b1};
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    tmo_cnt_r, tmo_cnt_s;
  logic [47:0]   frame_r, frame_s;
  logic [5:0]    idx_r, idx_s;
  logic [1:0]    rtype_r, rtype_s;
  logic [134:0]  shreg_r, shreg_s;
  logic [6:0]    crc_r, crc_s;
  logic          out_r, out_s;
  logic          oe_r, oe_s;
  logic          inhibit_r, inhibit_s;
  logic          complete_r, complete_s;
  logic          tmo_err_r, tmo_err_s;
  logic          crc_err_r, crc_err_s;
  logic          end_err_r, end_err_s;
  logic          idx_err_r, idx_err_s;
  logic          we0_r, we0_s;
  logic          we_hi_r, we_hi_s;
  logic [31:0]   resp0_r, resp0_s, resp1_r, resp1_s, resp2_r, resp2_s, resp3_r, resp3_s;
  logic [135:0]  rx_vec_s;
  logic [7:0]    rx_pos_s;
  logic          long_s;
  logic          unused_s;

  assign unused_s = ^{bus.cmd_in[15:14], bus.cmd_in[7:2], rx_vec_s[135:128]};

  // Next-state and next-output computation for the whole engine.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    frame_s    = frame_r;
    idx_s      = idx_r;
    rtype_s    = rtype_r;
    shreg_s    = shreg_r;
    crc_s      = crc_r;
    out_s      = out_r;
    oe_s       = oe_r;
    inhibit_s  = inhibit_r;
    complete_s = 1'b0;
    tmo_err_s  = 1'b0;
    crc_err_s  = 1'b0;
    end_err_s  = 1'b0;
    idx_err_s  = 1'b0;
    we0_s      = 1'b0;
    we_hi_s    = 1'b0;
    resp0_s    = resp0_r;
    resp1_s    = resp1_r;
    resp2_s    = resp2_r;
    resp3_s    = resp3_r;
    // Response bit k counts from the start bit (k = 0).
    rx_vec_s   = {shreg_r, bus.sd_cmd_in};
    rx_pos_s   = bit_cnt_r + 8'd1;
    long_s     = (rtype_r == 2'b01);

    case (state_r)
      IDLE: begin
        out_s     = 1'b1;
        oe_s      = 1'b0;
        inhibit_s = 1'b0;
        if (bus.cmd_start) begin
          idx_s     = bus.cmd_in[13:8];
          rtype_s   = bus.cmd_in[1:0];
          frame_s   = build_frame(bus.cmd_in[13:8], bus.arg_in);
          oe_s      = 1'b1;
          inhibit_s = 1'b1;
          bit_cnt_s = 8'd0;
          tmo_cnt_s = 8'd0;
          state_s   = SEND;
        end else begin
          state_s   = IDLE;
        end
      end

      SEND: begin
        if (bus.sd_bit_en) begin
          if (bit_cnt_r == FRAME_BITS) begin
            oe_s      = 1'b0;
            out_s     = 1'b1;
            bit_cnt_s = 8'd0;
            tmo_cnt_s = 8'd0;
            if (rtype_r == 2'b00) begin
              complete_s = 1'b1;
              state_s    = DONE;
            end else begin
              state_s    = WAIT;
            end
          end else begin
            out_s     = frame_r[47];
            frame_s   = {frame_r[46:0], 1'b1};
            bit_cnt_s = bit_cnt_r + 8'd1;
          end
        end else begin
          state_s = SEND;
        end
      end

      WAIT: begin
        if (bus.sd_bit_en) begin
          if (!bus.sd_cmd_in) begin
            shreg_s   = '0;
            crc_s     = 7'h00;
            bit_cnt_s = 8'd0;
            tmo_cnt_s = 8'd0;
            state_s   = RECV;
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_err_s = 1'b1;
            bit_cnt_s = 8'd0;
            tmo_cnt_s = 8'd0;
            state_s   = DONE;
          end else begin
            tmo_cnt_s = tmo_cnt_r + 8'd1;
          end
        end else begin
          state_s = WAIT;
        end
      end

      RECV: begin
        if (bus.sd_bit_en) begin
          shreg_s = rx_vec_s[134:0];
          // CRC covers [47:8] of R1-style frames and [127:8] of R2 frames.
          if (long_s ? (rx_pos_s >= 8'd8 && rx_pos_s <= 8'd127) : (rx_pos_s <= 8'd39)) begin
            crc_s = crc7_step(crc_r, bus.sd_cmd_in);
          end else begin
            crc_s = crc_r;
          end
          if (bit_cnt_r == (long_s ? LAST136 : LAST48)) begin
            crc_err_s  = (rx_vec_s[7:1] != crc_r);
            end_err_s  = ~rx_vec_s[0];
            complete_s = 1'b1;
            we0_s      = 1'b1;
            resp0_s    = rx_vec_s[39:8];
            bit_cnt_s  = 8'd0;
            tmo_cnt_s  = 8'd0;
            state_s    = DONE;
            if (long_s) begin
              resp1_s = rx_vec_s[71:40];
              resp2_s = rx_vec_s[103:72];
              resp3_s = {8'h00, rx_vec_s[127:104]};
              we_hi_s = 1'b1;
            end else begin
              idx_err_s = (rx_vec_s[45:40] != idx_r);
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 8'd1;
          end
        end else begin
          state_s = RECV;
        end
      end

      DONE: begin
        inhibit_s = 1'b0;
        bit_cnt_s = 8'd0;
        tmo_cnt_s = 8'd0;
        state_s   = IDLE;
      end

      default: begin
        out_s     = 1'b1;
        oe_s      = 1'b0;
        inhibit_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and releases CMD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 8'd0;
      tmo_cnt_r  <= 8'd0;
      frame_r    <= 48'h0;
      idx_r      <= 6'd0;
      rtype_r    <= 2'b00;
      shreg_r    <= '0;
      crc_r      <= 7'h00;
      out_r      <= 1'b1;
      oe_r       <= 1'b0;
      inhibit_r  <= 1'b0;
      complete_r <= 1'b0;
      tmo_err_r  <= 1'b0;
      crc_err_r  <= 1'b0;
      end_err_r  <= 1'b0;
      idx_err_r  <= 1'b0;
      we0_r      <= 1'b0;
      we_hi_r    <= 1'b0;
      resp0_r    <= 32'h0;
      resp1_r    <= 32'h0;
      resp2_r    <= 32'h0;
      resp3_r    <= 32'h0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      frame_r    <= frame_s;
      idx_r      <= idx_s;
      rtype_r    <= rtype_s;
      shreg_r    <= shreg_s;
      crc_r      <= crc_s;
      out_r      <= out_s;
      oe_r       <= oe_s;
      inhibit_r  <= inhibit_s;
      complete_r <= complete_s;
      tmo_err_r  <= tmo_err_s;
      crc_err_r  <= crc_err_s;
      end_err_r  <= end_err_s;
      idx_err_r  <= idx_err_s;
      we0_r      <= we0_s;
      we_hi_r    <= we_hi_s;
      resp0_r    <= resp0_s;
      resp1_r    <= resp1_s;
      resp2_r    <= resp2_s;
      resp3_r    <= resp3_s;
    end
  end

  assign bus.sd_cmd_out   = out_r;
  assign bus.sd_cmd_oe    = oe_r;
  assign bus.cmd_inhibit  = inhibit_r;
  assign bus.cmd_complete = complete_r;
  assign bus.timeout_err  = tmo_err_r;
  assign bus.crc_err      = crc_err_r;
  assign bus.end_bit_err  = end_err_r;
  assign bus.index_err    = idx_err_r;
  assign bus.resp0_we     = we0_r;
  assign bus.resp1_we     = we_hi_r;
  assign bus.resp2_we     = we_hi_r;
  assign bus.resp3_we     = we_hi_r;
  assign bus.resp0_d      = resp0_r;
  assign bus.resp1_d      = resp1_r;
  assign bus.resp2_d      = resp2_r;
  assign bus.resp3_d      = resp3_r;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: scripted card model with random strobe gaps,
// per-cycle comparison against expectations derived from the frame rules.
module tb_sd_cmd_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sd_cmd_engine_if bus();
  sd_cmd_engine #(.RESP_TIMEOUT(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // expectations for the next edge (e_*) and for the current cycle (c_*)
  logic e_out, e_oe, e_inh, c_out, c_oe, c_inh;
  logic [8:0] e_pulse, c_pulse;
  logic [31:0] e_resp [4];
  logic [31:0] c_resp [4];
  logic [47:0] cap;
  logic [8:0]  last_p;
  logic [31:0] last_r [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_pulses();
    return {bus.cmd_complete, bus.timeout_err, bus.crc_err, bus.end_bit_err, bus.index_err,
            bus.resp0_we, bus.resp1_we, bus.resp2_we, bus.resp3_we};
  endfunction

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] m_crc7(input logic [135:0] v, input int n);
    logic [142:0] w;
    w = '0;
    for (int j = 0; j < n; j++) w[j+7] = v[j];
    for (int i = n + 6; i >= 7; i--) if (w[i]) w[i-:8] = w[i-:8] ^ 8'h89;
    return w[6:0];
  endfunction

  function automatic logic [47:0] m_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] top;
    top = {2'b01, idx, arg};
    return {top, m_crc7(136'(top), 40), 1'b1};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      c_out = e_out; c_oe = e_oe; c_inh = e_inh; c_pulse = e_pulse;
      for (int k = 0; k < 4; k++) c_resp[k] = e_resp[k];
      @(negedge clk);
      if (reset) begin
        chk("rst_out", 64'(bus.sd_cmd_out), 64'd1);
        chk("rst_oe", 64'(bus.sd_cmd_oe), 64'd0);
        chk("rst_inhibit", 64'(bus.cmd_inhibit), 64'd0);
        chk("rst_pulses", 64'(dut_pulses()), 64'd0);
        chk("rst_resp", 64'(bus.resp0_d | bus.resp1_d | bus.resp2_d | bus.resp3_d), 64'd0);
      end else if (chk_on) begin
        chk("cmd_out", 64'(bus.sd_cmd_out), 64'(c_out));
        chk("cmd_oe", 64'(bus.sd_cmd_oe), 64'(c_oe));
        chk("inhibit", 64'(bus.cmd_inhibit), 64'(c_inh));
        chk("pulses", 64'(dut_pulses()), 64'(c_pulse));
        if (c_pulse[3]) chk("resp0_d", 64'(bus.resp0_d), 64'(c_resp[0]));
        if (c_pulse[2]) begin
          chk("resp1_d", 64'(bus.resp1_d), 64'(c_resp[1]));
          chk("resp2_d", 64'(bus.resp2_d), 64'(c_resp[2]));
          chk("resp3_d", 64'(bus.resp3_d), 64'(c_resp[3]));
        end
      end
    end
  end

  task automatic step(input logic st, input logic en);
    bus.cmd_start = st;
    bus.sd_bit_en = en;
    @(posedge clk);
    #1;
    e_pulse = '0;
    bus.cmd_start = 1'b0;
    bus.sd_bit_en = 1'b0;
    bus.sd_cmd_in = 1'($urandom);
  endtask

  // idle cycles between strobes, with occasional ignored cmd_start pulses
  task automatic gaps();
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.cmd_in = 16'($urandom);
        bus.arg_in = $urandom;
        step(1'b1, 1'b0);
      end else begin
        step(1'b0, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    e_out = 1'b1; e_oe = 1'b0; e_inh = 1'b0; e_pulse = '0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // lat < 0 holds the line high until timeout; bad: 1 flip CRC bit, 4 end bit 0
  task automatic run_cmd(input logic [5:0] idx, input logic [1:0] rt, input logic [31:0] arg,
                         input int lat, input int bad, input logic [5:0] ridx,
                         input logic [31:0] stat, input logic [119:0] pay, input int abort_at);
    logic [47:0] fr;
    logic [135:0] tv;
    logic [39:0] top;
    int len;
    logic [8:0] pend;
    fr = m_frame(idx, arg);
    cap = '0;
    bus.cmd_in = {2'b00, idx, 6'b000000, rt};
    bus.arg_in = arg;
    e_inh = 1'b1; e_oe = 1'b1; e_out = 1'b1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 48; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      gaps();
      e_out = fr[47-i];
      step(1'b0, 1'b1);
      cap = {cap[46:0], bus.sd_cmd_out};
    end
    gaps();
    e_oe = 1'b0; e_out = 1'b1;
    if (rt == 2'b00) e_pulse[8] = 1'b1;
    step(1'b0, 1'b1);
    last_p = dut_pulses();
    if (rt == 2'b00) begin
      e_inh = 1'b0;
      step(1'b0, 1'b0);
      return;
    end
    if (lat < 0) begin
      for (int j = 0; j < 64; j++) begin
        gaps();
        bus.sd_cmd_in = 1'b1;
        if (j == 63) e_pulse[7] = 1'b1;
        step(1'b0, 1'b1);
      end
      last_p = dut_pulses();
      e_inh = 1'b0;
      step(1'b0, 1'b0);
      return;
    end
    for (int j = 0; j < lat; j++) begin
      gaps();
      bus.sd_cmd_in = 1'b1;
      step(1'b0, 1'b1);
    end
    tv = '0;
    if (rt == 2'b01) begin
      len = 136;
      tv = {8'h3F, pay, m_crc7(136'(pay), 120), 1'b1};
    end else begin
      len = 48;
      top = {2'b00, ridx, stat};
      tv[47:0] = {top, m_crc7(136'(top), 40), 1'b1};
    end
    if (bad & 1) tv[3] = ~tv[3];
    if (bad & 4) tv[0] = 1'b0;
    if (len == 136) begin
      e_resp[0] = tv[39:8];
      e_resp[1] = tv[71:40];
      e_resp[2] = tv[103:72];
      e_resp[3] = {8'h00, tv[127:104]};
      pend = {1'b1, 1'b0, tv[7:1] != m_crc7(136'(tv[127:8]), 120), ~tv[0], 1'b0, 4'b1111};
    end else begin
      e_resp[0] = tv[39:8];
      pend = {1'b1, 1'b0, tv[7:1] != m_crc7(136'(tv[47:8]), 40), ~tv[0],
              tv[45:40] != idx, 4'b1000};
    end
    for (int b = 0; b < len; b++) begin
      gaps();
      bus.sd_cmd_in = tv[len-1-b];
      if (b == len - 1) e_pulse = pend;
      step(1'b0, 1'b1);
    end
    last_p = dut_pulses();
    last_r[0] = bus.resp0_d; last_r[1] = bus.resp1_d;
    last_r[2] = bus.resp2_d; last_r[3] = bus.resp3_d;
    e_inh = 1'b0;
    step(1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [127:0] rnd;
    logic [5:0] ri, rx;
    logic [1:0] rt;
    int lat, bad, ab;
    bus.cmd_start = 1'b0; bus.cmd_in = 16'h0; bus.arg_in = 32'h0;
    bus.sd_bit_en = 1'b0; bus.sd_cmd_in = 1'b1;
    e_out = 1'b1; e_oe = 1'b0; e_inh = 1'b0; e_pulse = '0;
    for (int k = 0; k < 4; k++) begin e_resp[k] = 32'h0; last_r[k] = 32'h0; end
    last_p = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_on = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // pin the model against known frames
    chk("model_cmd0", 64'(m_frame(6'd0, 32'h0)), 64'h400000000095);
    chk("model_cmd8", 64'(m_frame(6'd8, 32'h1AA)), 64'h48000001AA87);
    chk("model_cmd55", 64'(m_frame(6'd55, 32'h0)), 64'h770000000065);

    // CMD0, no response
    run_cmd(6'd0, 2'b00, 32'h0, 0, 0, 6'd0, 32'h0, 120'h0, -1);
    chk("cmd0_line", 64'(cap), 64'h400000000095);
    chk("cmd0_pulses", 64'(last_p), 64'h100);

    // CMD17 with valid R1
    run_cmd(6'd17, 2'b10, 32'h00001000, 3, 0, 6'd17, 32'h00000900, 120'h0, -1);
    chk("cmd17_resp0", 64'(last_r[0]), 64'h900);
    chk("cmd17_pulses", 64'(last_p), 64'h108);

    // CMD8 timeout
    run_cmd(6'd8, 2'b10, 32'h1AA, -1, 0, 6'd8, 32'h0, 120'h0, -1);
    chk("tmo_pulses", 64'(last_p), 64'h080);

    // corrupted CRC and wrong index
    run_cmd(6'd17, 2'b11, 32'h00001000, 0, 1, 6'd5, 32'h00000900, 120'h0, -1);
    chk("bad_pulses", 64'(last_p), 64'h158);
    chk("bad_resp0", 64'(last_r[0]), 64'h900);

    // R2 CID
    run_cmd(6'd2, 2'b01, 32'h0, 10, 0, 6'd0, 32'h0, 120'h112233445566778899AABBCCDDEEFF, -1);
    chk("r2_resp0", 64'(last_r[0]), 64'hCCDDEEFF);
    chk("r2_resp3", 64'(last_r[3]), 64'h00112233);
    chk("r2_pulses", 64'(last_p), 64'h10F);

    // latest possible start bit, end bit error
    run_cmd(6'd13, 2'b10, 32'hCAFE0000, 63, 4, 6'd13, 32'hDEADBEEF, 120'h0, -1);
    chk("late_pulses", 64'(last_p), 64'h128);

    // abort at bit 20, then a fresh frame
    run_cmd(6'd24, 2'b10, 32'hFFFFFFFF, 0, 0, 6'd24, 32'h0, 120'h0, 20);
    run_cmd(6'd0, 2'b00, 32'h0, 0, 0, 6'd0, 32'h0, 120'h0, -1);
    chk("abort_line", 64'(cap), 64'h400000000095);

    for (int n = 0; n < 30; n++) begin
      ri  = 6'($urandom);
      rt  = 2'($urandom);
      lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 63));
      bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      rx  = (bad & 2) ? (ri ^ 6'(1 + $urandom_range(0, 62))) : ri;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 47)) : -1;
      run_cmd(ri, rt, $urandom, lat, bad, rx, $urandom, rnd[119:0], ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 64, maximum SD bit-times from end bit to response start bit.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cmd_start, input, 1, one-cycle pulse on command register write.
REQ-005 SHALL have port cmd_in, input, 16, command register: [13:8] index, [1:0] response type (00 none, 01 136-bit, 10/11 48-bit).
REQ-006 SHALL have port arg_in, input, 32, command argument.
REQ-007 SHALL have port sd_bit_en, input, 1, one-cycle strobe per SD clock period.
REQ-008 SHALL have ports sd_cmd_out and sd_cmd_oe, output, 1 each, CMD line drive value and drive enable.
REQ-009 SHALL have port sd_cmd_in, input, 1, synchronized CMD line.
REQ-010 SHALL have ports resp0_d..resp3_d, output, 32 each, and resp0_we..resp3_we, output, 1 each, write data and one-cycle enables to the response registers.
REQ-011 SHALL have port cmd_inhibit, output, 1, level: command in progress.
REQ-012 SHALL have ports cmd_complete, timeout_err, crc_err, end_bit_err, index_err, output, 1 each, one-cycle pulses.

Function
REQ-013 SHALL implement states IDLE, SEND, WAIT, RECV, DONE.
REQ-014 In IDLE, cmd_start SHALL latch cmd_in and arg_in, set cmd_inhibit the next cycle, and enter SEND.
REQ-015 cmd_start while cmd_inhibit=1 SHALL be ignored with no error.
REQ-016 SEND SHALL transmit 48 bits MSB-first: 0, 1, index[5:0], arg[31:0], CRC7 over the preceding 40 bits, 1.
REQ-017 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0.
REQ-018 In SEND, sd_cmd_oe SHALL be 1, and sd_cmd_out SHALL advance exactly one bit per sd_bit_en cycle.
REQ-019 The first frame bit SHALL appear on the first sd_bit_en after entering SEND.
REQ-020 On the sd_bit_en following the end bit, sd_cmd_oe SHALL drop to 0.
REQ-021 After REQ-020, response type 00 SHALL go to DONE; all other types SHALL go to WAIT.
REQ-022 WAIT SHALL sample sd_cmd_in on each sd_bit_en.
REQ-023 In WAIT, the first sampled 0 SHALL be the start bit and SHALL enter RECV.
REQ-024 In WAIT, RESP_TIMEOUT samples without a 0 SHALL pulse timeout_err and enter DONE with no resp*_we asserted.
REQ-025 RECV SHALL shift in 47 more bits for type 10/11 and 135 more bits for type 01, sampling only on sd_bit_en.
REQ-026 For a 48-bit response, resp0_d SHALL be bits [39:8] with resp0_we pulsed once; resp1..3 SHALL NOT be written.
REQ-027 For a 48-bit response, index_err SHALL pulse if bits [45:40] differ from the sent index.
REQ-028 For a 48-bit response, crc_err SHALL pulse if bits [7:1] differ from CRC7 over bits [47:8].
REQ-029 For a 136-bit response, response bits [127:8] SHALL map to a 120-bit value packed LSB-first into resp0..resp3.
REQ-030 For a 136-bit response, resp3_d[31:24] SHALL be 0, and all four resp*_we SHALL pulse in the same cycle.
REQ-031 For a 136-bit response, crc_err SHALL be checked with CRC7 over bits [127:8] against bits [7:1]; the index SHALL NOT be checked.
REQ-032 For any response, end_bit_err SHALL pulse if the last bit is 0.
REQ-033 Response register writes SHALL occur even when crc_err, index_err or end_bit_err fires.
REQ-034 All error pulses and resp*_we SHALL assert in the cycle after the final bit is sampled, coincident with entry to DONE.
REQ-035 DONE SHALL last one cycle: cmd_complete pulses only if timeout_err did not fire, cmd_inhibit clears, and the state returns to IDLE.
REQ-036 Bit counter and timeout counter SHALL be 8-bit saturating-free and SHALL be reset on every state entry.

Reset
REQ-037 While reset=1, state SHALL be IDLE and sd_cmd_out=1.
REQ-038 While reset=1, sd_cmd_oe, cmd_inhibit, all pulses and all resp*_we SHALL be 0, and all resp*_d SHALL be 0.
REQ-039 Reset asserted mid-frame SHALL abort immediately, release the CMD line, produce no completion or error pulse, and discard latched command data.

Verification
REQ-040 CMD0 test: cmd_in=0x0000, arg=0 -> line carries 0x400000000095, then oe=0, cmd_complete exactly 1 cycle after the end bit period, no resp*_we.
REQ-041 CMD17 test: cmd_in=0x1102, arg=0x00001000; card returns valid R1 index 17, status 0x00000900 -> resp0_d=0x00000900, resp0_we pulse, cmd_complete, no errors.
REQ-042 Timeout test: CMD8 with type 10 and the line held at 1 -> timeout_err after exactly 64 strobes, no cmd_complete, no resp*_we, cmd_inhibit cleared.
REQ-043 Corrupted-response test: R1 with a corrupted CRC bit and index 5 instead of 17 -> crc_err and index_err pulse in the same cycle, resp0 still written, cmd_complete pulses.
REQ-044 R2 test: CID response 0x3F followed by a 120-bit pattern and a valid CRC -> resp0..3 hold the pattern, resp3_d[31:24]=0, four we pulses coincident.
REQ-045 Abort test: reset at bit 20 of SEND, then cmd_start 3 cycles after release -> clean new frame from bit 0; cmd_start during WAIT is ignored.
